// File: rtl/data_mem_sync.sv
// data_mem_sync: parametrised single-port data RAM with a registered read.
//
// A write-first path forwards write data straight to read_data. After reset a
// hardware sequencer can write CLEAR_VALUE into every word. busy stays high
// while the sequencer runs, and user accesses are ignored during that time.
//
// Optional feature: define DATA_MEM_PARITY_EN to store an even-parity bit per
// word and add the parity_err output, which is registered with read_data.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   address     word address for read and write (AW bits)
//   write_data  data to store (DW bits)
//   wren        write enable, active-low (0 = write, 1 = read only)
//   read_data   registered read data (DW bits)
//   busy        high while the clear sequence runs
//   parity_err  parity mismatch on the last read (DATA_MEM_PARITY_EN only)
module data_mem_sync #(
  parameter int              DW             = 8,
  parameter int              AW             = 8,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0]   CLEAR_VALUE    = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] write_data,
  input  logic          wren,
  output logic [DW-1:0] read_data,
`ifdef DATA_MEM_PARITY_EN
  output logic          parity_err,
`endif
  output logic          busy
);

  localparam int            DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DW-1:0]   read_data_q, read_data_d;

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_q [DEPTH];

`ifdef DATA_MEM_PARITY_EN
  logic            par_q [DEPTH];
  logic            parity_err_q, parity_err_d;
`endif

  // State register. Reset is sampled only at the clock edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr_q   <= '0;
      read_data_q <= '0;
`ifdef DATA_MEM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      read_data_q <= read_data_d;
`ifdef DATA_MEM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic. The sequencer leaves CLEAR after writing the last word.
  // The pointer then wraps to 0 on that same edge.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_ADDR) state_d = IDLE;
    end
  end

  // Output and datapath logic. A reset cycle never writes the memory.
  always_comb begin
    busy        = (state_q == CLEAR);
    mem_we      = 1'b0;
    mem_addr    = address;
    mem_wdata   = write_data;
    read_data_d = '0;
`ifdef DATA_MEM_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_q;
        mem_wdata = CLEAR_VALUE;
      end else if (!wren) begin
        mem_we      = 1'b1;
        read_data_d = write_data;        // write-first forwarding
      end else begin
        read_data_d = mem_q[address];
`ifdef DATA_MEM_PARITY_EN
        parity_err_d = (^mem_q[address]) != par_q[address];
`endif
      end
    end
  end

  // Storage array. It is initialised by the clear sequencer, not by reset.
  // NOTE: memories are never reset in an always_ff; this keeps them mappable to RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
`ifdef DATA_MEM_PARITY_EN
      par_q[mem_addr] <= ^mem_wdata;
`endif
    end
  end

  assign read_data = read_data_q;
`ifdef DATA_MEM_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_data_mem_sync.sv
module tb_data_mem_sync;

  localparam int            DW    = 8;
  localparam int            AW    = 4;
  localparam int            DEPTH = 16;
  localparam logic [DW-1:0] CV    = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] write_data = '0;
  logic          wren = 1'b1;
  logic [DW-1:0] read_data;
  logic          busy;
`ifdef DATA_MEM_PARITY_EN
  logic          parity_err;
`endif

  int errors = 0;
  int checks = 0;

  // Reference contents: the whole array is known once a clear has run.
  logic [DW-1:0] model [DEPTH];

  data_mem_sync #(
    .DW(DW), .AW(AW), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .wren(wren), .read_data(read_data),
`ifdef DATA_MEM_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge. Outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count the cycles busy stays high after reset is released.
  // During those cycles, poke a user write and check that read_data holds 0.
  task automatic count_busy(output int n);
    n = 0;
    rst = 1'b0;
    wren = 1'b0; address = 4'd5; write_data = 8'h3C;
    while (busy && n < 64) begin
      step();
      n++;
      if (busy) begin
        checks++;
        if (read_data !== 8'h00) begin
          errors++;
          $display("FAIL clear_rd_zero: read_data=%h expected 00 at cycle %0d", read_data, n);
        end
      end
    end
    wren = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = CV;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; step(); step();
    checks++;
    if (busy !== 1'b1 || read_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy=%b read_data=%h expected busy=1 read_data=00", busy, read_data);
    end
    count_busy(n);
    checks++;
    if (n !== DEPTH || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_len: busy cycles=%0d expected %0d (busy now %b)", n, DEPTH, busy);
    end
    for (int a = 0; a < DEPTH; a++) begin
      wren = 1'b1; address = AW'(a); step();
      checks++;
      if (read_data !== CV) begin
        errors++;
        $display("FAIL clear_value@%0d: read_data=%h expected %h", a, read_data, CV);
      end
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] vals [3];
    vals[0] = 8'h21; vals[1] = 8'h43; vals[2] = 8'h65;
    for (int i = 0; i < 3; i++) begin
      wren = 1'b0; address = AW'(i); write_data = vals[i]; step();
      model[i] = vals[i];
    end
    wren = 1'b1; write_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      address = AW'(i); step();
      checks++;
      if (read_data !== vals[i]) begin
        errors++;
        $display("FAIL latency_rd@%0d: read_data=%h expected %h", i, read_data, vals[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    wren = 1'b0; address = 4'd2; write_data = 8'h87; step();
    model[2] = 8'h87;
    checks++;
    if (read_data !== 8'h87) begin
      errors++;
      $display("FAIL forward_same_edge: read_data=%h expected 87", read_data);
    end
    wren = 1'b1; write_data = 8'h00; step();
    checks++;
    if (read_data !== 8'h87) begin
      errors++;
      $display("FAIL forward_readback: read_data=%h expected 87", read_data);
    end
  endtask

  task automatic test_wren_polarity();
    wren = 1'b0; address = 4'd3; write_data = 8'hA9; step();
    model[3] = 8'hA9;
    wren = 1'b1; write_data = 8'hFF; step();
    checks++;
    if (read_data !== 8'hA9) begin
      errors++;
      $display("FAIL wren_high_no_write: read_data=%h expected A9", read_data);
    end
    write_data = 8'h00; step();
    checks++;
    if (read_data !== 8'hA9) begin
      errors++;
      $display("FAIL wren_readback: read_data=%h expected A9", read_data);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp;
    logic          we_n;
    for (int i = 0; i < 300; i++) begin
      a    = AW'($urandom_range(DEPTH - 1));
      d    = DW'($urandom_range(255));
      we_n = 1'($urandom_range(1));
      address = a; write_data = d; wren = we_n;
      if (!we_n) begin model[a] = d; exp = d; end
      else exp = model[a];
      step();
      checks++;
      if (read_data !== exp) begin
        errors++;
        $display("FAIL random[%0d] @%0d wren=%b: read_data=%h expected %h", i, a, we_n, read_data, exp);
      end
`ifdef DATA_MEM_PARITY_EN
      checks++;
      if (parity_err !== 1'b0) begin
        errors++;
        $display("FAIL random_parity[%0d]: parity_err=%b expected 0", i, parity_err);
      end
`endif
    end
    wren = 1'b1;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1; step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_busy: busy=%b expected 1", busy);
    end
    count_busy(n);
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL mid_busy_len: busy cycles=%0d expected %0d", n, DEPTH);
    end
    address = 4'd5; wren = 1'b1; step();
    checks++;
    if (read_data !== CV) begin
      errors++;
      $display("FAIL busy_write_ignored: read_data=%h expected %h", read_data, CV);
    end
    address = 4'd2; step();
    checks++;
    if (read_data !== CV) begin
      errors++;
      $display("FAIL reclear@2: read_data=%h expected %h", read_data, CV);
    end
  endtask

`ifdef DATA_MEM_PARITY_EN
  task automatic test_parity();
    wren = 1'b0; address = 4'd4; write_data = 8'h0F; step();
    wren = 1'b1;
    dut.mem_q[4] = dut.mem_q[4] ^ 8'h01;
    step();
    checks++;
    if (parity_err !== 1'b1 || read_data !== 8'h0E) begin
      errors++;
      $display("FAIL parity_flip: parity_err=%b read_data=%h expected 1 0E", parity_err, read_data);
    end
    address = 4'd5; step();
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_clean: parity_err=%b expected 0", parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_forwarding();
    test_wren_polarity();
    test_random();
    test_reset_mid_clear();
`ifdef DATA_MEM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
